ehgu_rst_seq_ctrl: RTL and testbench
====================================

// Module: ehgu_rst_seq_ctrl
// PURPOSE
// Reset sequencer/arbiter for the leaf resets of the EHGU reset tree.
// After global reset release, leaf resets are released one by one in index order, spaced GAP cycles apart.
// After boot, leaves request a soft reset through a 4-phase req/ack handshake.
// A round-robin arbiter serves one leaf at a time; the served leaf is held in reset for HOLD cycles.
// PARAMETERS
// LEAFS  4  number of leaf reset outputs, >=1
// GAP    4  cycles between consecutive leaf releases (boot) and from release to ack (soft); >=1
// HOLD   8  cycles a leaf is held in reset for a soft reset; >=1
// CNT_W  8  width of soft-reset counter (used only with EHGU_RST_SEQ_CNT_EN)
// PORTS
// clk         in   1       clock
// rstn_array  in   1       reset: asynchronous, active-low
// soft_req    in   LEAFS   per-leaf soft reset request, level, 4-phase
// soft_ack    out  LEAFS   per-leaf ack; high from completion until that leaf's req drops
// rstn_leaf   out  LEAFS   registered active-low leaf resets
// boot_done   out  1       high once all leaves are released after global reset
// busy        out  1       high while a soft reset is in progress (ASSERT..ACK)
// BEHAVIOUR
// Reset values while rstn_array=0:
// - rstn_leaf=0, soft_ack=0, boot_done=0, busy=0
// - state=BOOT, leaf idx=0, RR pointer=0 (leaf 0 has highest priority)
// Edge numbering: edge 1 is the first rising clk edge after rstn_array deasserts.
// BOOT:
// - rstn_leaf[i] rises at edge (i+1)*GAP.
// - boot_done rises at edge LEAFS*GAP, together with the last leaf; then -> IDLE.
// - soft_req is ignored during BOOT; requests stay pending because they are level.
// IDLE, arbitration:
// - Grant g = first i with soft_req[i]=1, searching from the RR pointer upward with wrap.
// - At the grant edge N: rstn_leaf[g]<=0, busy<=1, RR pointer<=(g+1)%LEAFS, -> ASSERT.
// ASSERT: rstn_leaf[g] is held 0; at edge N+HOLD, rstn_leaf[g]<=1 -> SETTLE.
// SETTLE: at edge N+HOLD+GAP, soft_ack[g]<=1 -> ACK.
// ACK:
// - soft_ack[g] stays 1 while soft_req[g]=1.
// - At the first edge sampling soft_req[g]=0: soft_ack[g]<=0, busy<=0, -> IDLE.
// - The next grant is possible at the edge after that.
// Leaves not being served keep rstn_leaf=1 throughout a soft reset; at most one leaf is in soft reset at a time.
// Requests for other leaves raised during ASSERT/SETTLE/ACK are pending only; they are arbitrated in IDLE.
// A soft_req[g] drop during ASSERT or SETTLE has no effect: the sequence completes.
// - soft_ack[g] still pulses for exactly 1 cycle, since req is already low.
// Global reset mid-operation: async, everything returns to reset values at once; BOOT restarts from leaf 0.
// Counters are sized $clog2(max(GAP,HOLD)+1); no wrap is possible within a state.
// Only one hot bit in soft_ack at any time.
// CONFIGURATION
// EHGU_RST_SEQ_CNT_EN defined:
// - Adds output soft_cnt [CNT_W-1:0], reset 0.
// - It increments on every ACK->IDLE transition and saturates at 2^CNT_W-1.
// EHGU_RST_SEQ_CNT_EN undefined: no soft_cnt port and no counter logic; all other behaviour is identical.
// TESTING
// 1. Boot, LEAFS=4 GAP=4: release rstn_array -> rstn_leaf 0001@e4, 0011@e8, 0111@e12, 1111@e16; boot_done@e16.
// 2. Single soft: soft_req[2]=1 at grant edge N, HOLD=8 -> rstn_leaf[2]=0 during N..N+7, 1@N+8.
//    - soft_ack[2]=1@N+12; drop req -> ack=0 and busy=0 next edge.
// 3. All four reqs high at once after boot (ptr=0) -> service order 0,1,2,3.
//    - Re-raise 0 and 3 after serving 3 -> order 0 then 3.
// 4. soft_req[1]=1 from edge 1 (during boot) -> no effect until boot_done.
//    - Grant at edge 17 (GAP=4, LEAFS=4).
// 5. Assert rstn_array mid-ASSERT on leaf 1 -> all outputs 0 immediately.
//    - After release, boot sequence as in test 1.
// 6. With EHGU_RST_SEQ_CNT_EN, CNT_W=2: 5 completed soft resets -> soft_cnt=1,2,3,3,3.
//    - Global reset -> soft_cnt=0.

Source files
------------

// File: rtl/ehgu_rst_seq_ctrl.sv
// ehgu_rst_seq_ctrl: staggered boot release of leaf resets plus round-robin soft reset arbiter.
// Optional EHGU_RST_SEQ_CNT_EN adds a saturating soft_cnt of completed soft resets.
module ehgu_rst_seq_ctrl #(
  parameter int LEAFS = 4,
  parameter int GAP   = 4,
  parameter int HOLD  = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn_array,
  input  logic [LEAFS-1:0] soft_req,
  output logic [LEAFS-1:0] soft_ack,
  output logic [LEAFS-1:0] rstn_leaf,
  output logic             boot_done,
  output logic             busy
`ifdef EHGU_RST_SEQ_CNT_EN
  ,output logic [CNT_W-1:0] soft_cnt
`endif
);
  localparam int IW = LEAFS > 1 ? $clog2(LEAFS) : 1;
  localparam int CW = $clog2((GAP > HOLD ? GAP : HOLD) + 1);
  if (LEAFS < 1 || GAP < 1 || HOLD < 1 || CNT_W < 1) begin : g_bad_param
    $error("ehgu_rst_seq_ctrl: illegal parameter value");
  end
  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_ASSERT, S_SETTLE, S_ACK} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt, ptr, ptr_nxt, g, g_nxt, gnt;
  logic [LEAFS-1:0] leaf_nxt, ack_nxt;
  logic done_nxt, busy_nxt;
  // Search downward from the farthest candidate so the one nearest ptr wins.
  always_comb begin
    gnt = '0;
    for (int k = LEAFS - 1; k >= 0; k--)
      if (soft_req[IW'((int'(ptr) + k) % LEAFS)]) gnt = IW'((int'(ptr) + k) % LEAFS);
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    ptr_nxt   = ptr;
    g_nxt     = g;
    leaf_nxt  = rstn_leaf;
    ack_nxt   = soft_ack;
    done_nxt  = boot_done;
    busy_nxt  = busy;
    case (state)
      S_BOOT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(GAP - 1)) begin
          cnt_nxt       = '0;
          leaf_nxt[idx] = 1'b1;
          idx_nxt       = idx + 1'b1;
          if (int'(idx) == LEAFS - 1) begin
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      S_IDLE: if (|soft_req) begin
        g_nxt         = gnt;
        leaf_nxt[gnt] = 1'b0;
        busy_nxt      = 1'b1;
        cnt_nxt       = '0;
        ptr_nxt       = int'(gnt) == LEAFS - 1 ? '0 : gnt + 1'b1;
        state_nxt     = S_ASSERT;
      end
      S_ASSERT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(HOLD - 1)) begin
          cnt_nxt     = '0;
          leaf_nxt[g] = 1'b1;
          state_nxt   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(GAP - 1)) begin
          cnt_nxt    = '0;
          ack_nxt[g] = 1'b1;
          state_nxt  = S_ACK;
        end
      end
      S_ACK: if (!soft_req[g]) begin
        ack_nxt[g] = 1'b0;
        busy_nxt   = 1'b0;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rstn_array)
    if (!rstn_array) begin
      state     <= S_BOOT;
      cnt       <= '0;
      idx       <= '0;
      ptr       <= '0;
      g         <= '0;
      rstn_leaf <= '0;
      soft_ack  <= '0;
      boot_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      ptr       <= ptr_nxt;
      g         <= g_nxt;
      rstn_leaf <= leaf_nxt;
      soft_ack  <= ack_nxt;
      boot_done <= done_nxt;
      busy      <= busy_nxt;
    end
`ifdef EHGU_RST_SEQ_CNT_EN
  logic fin;
  assign fin = state == S_ACK && !soft_req[g];
  always_ff @(posedge clk or negedge rstn_array)
    if (!rstn_array) soft_cnt <= '0;
    else if (fin && soft_cnt != '1) soft_cnt <= soft_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_ehgu_rst_seq_ctrl.sv
// tb_ehgu_rst_seq_ctrl: directed checks of boot release, soft reset timing, round-robin order and async reset.
module tb_ehgu_rst_seq_ctrl;
  logic clk = 1'b0;
  logic rstn_array = 1'b1;
  logic [3:0] soft_req = '0;
  logic [3:0] soft_ack, rstn_leaf;
  logic boot_done, busy;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef EHGU_RST_SEQ_CNT_EN
  logic [1:0] soft_cnt;
  int exp_cnt = 0;
`endif
  ehgu_rst_seq_ctrl #(.LEAFS(4), .GAP(4), .HOLD(8), .CNT_W(2)) dut (
    .clk(clk),
    .rstn_array(rstn_array),
    .soft_req(soft_req),
    .soft_ack(soft_ack),
    .rstn_leaf(rstn_leaf),
    .boot_done(boot_done),
    .busy(busy)
`ifdef EHGU_RST_SEQ_CNT_EN
    ,.soft_cnt(soft_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic completed();
`ifdef EHGU_RST_SEQ_CNT_EN
    if (exp_cnt < 3) exp_cnt++;
    chk("soft_cnt", 32'(soft_cnt), 32'(exp_cnt));
`endif
  endtask
  task automatic reset_dut();
    rstn_array = 1'b0;
    #1;
    chk("rst_leaf", rstn_leaf, 0);
    chk("rst_ack", soft_ack, 0);
    chk("rst_done", boot_done, 0);
    chk("rst_busy", busy, 0);
`ifdef EHGU_RST_SEQ_CNT_EN
    exp_cnt = 0;
    chk("rst_cnt", 32'(soft_cnt), 0);
`endif
    tick();
    tick();
  endtask
  task automatic boot_check();
    logic [3:0] e_leaf;
    rstn_array = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      for (int i = 0; i < 4; i++) e_leaf[i] = e >= (i + 1) * 4;
      chk("boot_leaf", rstn_leaf, e_leaf);
      chk("boot_done", boot_done, e == 16);
    end
    chk("boot_busy", busy, 0);
  endtask
  task automatic serve(int l);
    for (int n = 0; n < 40 && busy !== 1'b1; n++) tick();
    chk("grant_busy", busy, 1);
    chk("grant_leaf", rstn_leaf, 4'hF & ~(4'd1 << l));
    for (int n = 0; n < 40 && soft_ack === 4'd0; n++) tick();
    chk("serve_ack", soft_ack, 4'd1 << l);
    chk("serve_leaf", rstn_leaf, 4'hF);
    soft_req[l] = 1'b0;
    tick();
    chk("serve_ack_drop", soft_ack, 0);
    chk("serve_idle", busy, 0);
    completed();
  endtask
  initial begin
    reset_dut();
    boot_check();
    // single soft reset on leaf 2, exact timing
    soft_req[2] = 1'b1;
    tick();
    chk("t2_grant_leaf", rstn_leaf, 4'b1011);
    chk("t2_grant_busy", busy, 1);
    repeat (7) tick();
    chk("t2_hold_end", rstn_leaf, 4'b1011);
    tick();
    chk("t2_release", rstn_leaf, 4'b1111);
    chk("t2_no_ack", soft_ack, 0);
    repeat (3) tick();
    chk("t2_ack_early", soft_ack, 0);
    tick();
    chk("t2_ack", soft_ack, 4'b0100);
    tick();
    chk("t2_ack_held", soft_ack, 4'b0100);
    chk("t2_busy_held", busy, 1);
    soft_req[2] = 1'b0;
    tick();
    chk("t2_ack_drop", soft_ack, 0);
    chk("t2_busy_drop", busy, 0);
    completed();
    // request dropped during ASSERT: ptr is 3, so leaf 0 wins after wrap
    soft_req[0] = 1'b1;
    tick();
    chk("drop_grant", rstn_leaf, 4'b1110);
    soft_req[0] = 1'b0;
    for (int n = 0; n < 40 && soft_ack === 4'd0; n++) tick();
    chk("drop_ack", soft_ack, 4'b0001);
    tick();
    chk("drop_ack_pulse", soft_ack, 0);
    chk("drop_busy", busy, 0);
    completed();
    // request held from edge 1 is ignored through boot, granted at edge 17
    rstn_array = 1'b0;
    #1;
    soft_req[1] = 1'b1;
    tick();
    boot_check();
    tick();
    chk("t4_grant_busy", busy, 1);
    chk("t4_grant_leaf", rstn_leaf, 4'b1101);
    tick();
    tick();
    // async reset mid-ASSERT
    soft_req = '0;
    reset_dut();
    boot_check();
    // round robin from ptr 0
    soft_req = 4'hF;
    serve(0);
    serve(1);
    serve(2);
    serve(3);
    soft_req = 4'b1001;
    serve(0);
    serve(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
